// File: rtl/pixel_render_pipeline.sv
// Two-stage sprite renderer: per-pixel rectangle hit test against a frame-latched object table,
// lowest-index priority colour select, and per-frame collision flag accumulation.
module pixel_render_pipeline #(
  parameter int unsigned         NUM_OBJECTS = 3,
  parameter int unsigned         COORD_W     = 16,
  parameter int unsigned         COLOUR_W    = 8,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 8'h00
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_OBJECTS*2*COORD_W-1:0]  obj_pos_in,
  input  logic [NUM_OBJECTS*2*COORD_W-1:0]  obj_size_in,
  input  logic [NUM_OBJECTS*COLOUR_W-1:0]   obj_colour_in,
  input  logic [NUM_OBJECTS-1:0]            obj_enable_in,
  input  logic                              frame_start,
  input  logic                              pix_valid_in,
  output logic                              pix_ready_out,
  input  logic [COORD_W-1:0]                pix_x,
  input  logic [COORD_W-1:0]                pix_y,
  output logic                              pix_valid_out,
  input  logic                              pix_ready_in,
  output logic [COLOUR_W-1:0]               pixel_out,
  output logic [NUM_OBJECTS-1:0]            collision_out
);

  localparam int unsigned PW = 2 * COORD_W;

  logic [NUM_OBJECTS*PW-1:0]       pos_q, pos_d, size_q, size_d;
  logic [NUM_OBJECTS*COLOUR_W-1:0] colour_q, colour_d;
  logic [NUM_OBJECTS-1:0]          enable_q, enable_d;
  logic                            s1_valid_q, s1_valid_d;
  logic [NUM_OBJECTS-1:0]          s1_hit_q, s1_hit_d;
  logic [COLOUR_W-1:0]             s1_colour_q, s1_colour_d;
  logic                            pix_valid_q, pix_valid_d;
  logic [COLOUR_W-1:0]             pixel_q, pixel_d;
  logic [NUM_OBJECTS-1:0]          s2_hit_q, s2_hit_d;
  logic [NUM_OBJECTS-1:0]          acc_q, acc_d, coll_q, coll_d;

  logic                            advance, transfer, multi_hit;
  logic [NUM_OBJECTS-1:0]          hit_c, acc_c;
  logic [COLOUR_W-1:0]             colour_c;

  // Extra top bit keeps lo+len from wrapping past the coordinate range.
  function automatic logic in_span(logic [COORD_W-1:0] p, logic [COORD_W-1:0] lo,
                                   logic [COORD_W-1:0] len);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + {1'b0, len};
    return (len != '0) && (p >= lo) && ({1'b0, p} < hi);
  endfunction

  // Walk from the highest index down so the lowest-index hit wins the colour.
  always_comb begin
    hit_c    = '0;
    colour_c = BG_COLOUR;
    for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
      hit_c[i] = enable_q[i]
               && in_span(pix_x, pos_q[i*PW+COORD_W +: COORD_W], size_q[i*PW+COORD_W +: COORD_W])
               && in_span(pix_y, pos_q[i*PW +: COORD_W], size_q[i*PW +: COORD_W]);
      if (hit_c[i]) colour_c = colour_q[i*COLOUR_W +: COLOUR_W];
    end
  end

  always_comb begin
    advance     = !pix_valid_q || pix_ready_in;
    transfer    = pix_valid_q && pix_ready_in;
    multi_hit   = |(s2_hit_q & (s2_hit_q - NUM_OBJECTS'(1)));
    acc_c       = acc_q | ((transfer && multi_hit) ? s2_hit_q : '0);

    s1_valid_d  = s1_valid_q;
    s1_hit_d    = s1_hit_q;
    s1_colour_d = s1_colour_q;
    pix_valid_d = pix_valid_q;
    pixel_d     = pixel_q;
    s2_hit_d    = s2_hit_q;
    if (advance) begin
      s1_valid_d  = pix_valid_in;
      s1_hit_d    = hit_c;
      s1_colour_d = colour_c;
      pix_valid_d = s1_valid_q;
      pixel_d     = s1_colour_q;
      s2_hit_d    = s1_hit_q;
    end

    pos_d    = pos_q;
    size_d   = size_q;
    colour_d = colour_q;
    enable_d = enable_q;
    coll_d   = coll_q;
    acc_d    = acc_c;
    if (frame_start) begin
      pos_d    = obj_pos_in;
      size_d   = obj_size_in;
      colour_d = obj_colour_in;
      enable_d = obj_enable_in;
      coll_d   = acc_c;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q       <= '0;
      size_q      <= '0;
      colour_q    <= '0;
      enable_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_colour_q <= BG_COLOUR;
      pix_valid_q <= 1'b0;
      pixel_q     <= BG_COLOUR;
      s2_hit_q    <= '0;
      acc_q       <= '0;
      coll_q      <= '0;
    end else begin
      pos_q       <= pos_d;
      size_q      <= size_d;
      colour_q    <= colour_d;
      enable_q    <= enable_d;
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_colour_q <= s1_colour_d;
      pix_valid_q <= pix_valid_d;
      pixel_q     <= pixel_d;
      s2_hit_q    <= s2_hit_d;
      acc_q       <= acc_d;
      coll_q      <= coll_d;
    end
  end

  assign pix_ready_out = advance;
  assign pix_valid_out = pix_valid_q;
  assign pixel_out     = pixel_q;
  assign collision_out = coll_q;

endmodule

// File: tb/tb_pixel_render_pipeline.sv
// Scoreboard bench: the driver pushes model results on acceptance, a negedge monitor pops and
// compares every transferred pixel, checks stall stability, latency and collision flags.
module tb_pixel_render_pipeline;
  localparam int N = 3;
  localparam int W = 16;
  localparam int C = 8;

  logic             clk, rst;
  logic [N*2*W-1:0] obj_pos_in, obj_size_in;
  logic [N*C-1:0]   obj_colour_in;
  logic [N-1:0]     obj_enable_in;
  logic             frame_start, pix_valid_in, pix_ready_out;
  logic [W-1:0]     pix_x, pix_y;
  logic             pix_valid_out, pix_ready_in;
  logic [C-1:0]     pixel_out;
  logic [N-1:0]     collision_out;

  pixel_render_pipeline #(
    .NUM_OBJECTS(N), .COORD_W(W), .COLOUR_W(C), .BG_COLOUR(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .obj_pos_in(obj_pos_in), .obj_size_in(obj_size_in),
    .obj_colour_in(obj_colour_in), .obj_enable_in(obj_enable_in),
    .frame_start(frame_start),
    .pix_valid_in(pix_valid_in), .pix_ready_out(pix_ready_out),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
    .pixel_out(pixel_out), .collision_out(collision_out)
  );

  typedef struct {
    logic [C-1:0] col;
    logic [N-1:0] hits;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [N-1:0] tb_acc = '0;
  bit           rand_ready = 0;

  logic [W-1:0] c_x[N], c_y[N], c_w[N], c_h[N], m_x[N], m_y[N], m_w[N], m_h[N];
  logic [C-1:0] c_col[N], m_col[N];
  logic         c_en[N], m_en[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    pix_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      pix_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      obj_pos_in[i*2*W +: 2*W]  = {c_x[i], c_y[i]};
      obj_size_in[i*2*W +: 2*W] = {c_w[i], c_h[i]};
      obj_colour_in[i*C +: C]   = c_col[i];
      obj_enable_in[i]          = c_en[i];
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int w, input int h,
                         input int col, input bit en);
    c_x[i] = 16'(x); c_y[i] = 16'(y); c_w[i] = 16'(w); c_h[i] = 16'(h);
    c_col[i] = 8'(col); c_en[i] = en;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_w[i] = '0; m_h[i] = '0; m_col[i] = '0; m_en[i] = 1'b0;
    end
  endtask

  // Reference: a pixel is inside [x, x+w) x [y, y+h) in unbounded integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] px, input logic [W-1:0] py);
    exp_t e;
    e.col  = 8'h00;
    e.hits = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_en[i] && int'(px) >= int'(m_x[i]) && int'(px) < int'(m_x[i]) + int'(m_w[i])
          && int'(py) >= int'(m_y[i]) && int'(py) < int'(m_y[i]) + int'(m_h[i])) begin
        e.hits[i] = 1'b1;
        e.col     = m_col[i];
      end
    end
    e.cyc = cyc;
    e.lat = !rand_ready;
    return e;
  endfunction

  // Called just after the edge that sampled frame_start.
  task automatic frame_done();
    for (int i = 0; i < N; i++) begin
      m_x[i] = c_x[i]; m_y[i] = c_y[i]; m_w[i] = c_w[i]; m_h[i] = c_h[i];
      m_col[i] = c_col[i]; m_en[i] = c_en[i];
    end
    check("collision", 32'(collision_out), 32'(tb_acc));
    tb_acc = '0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    frame_done();
  endtask

  task automatic send(input int x, input int y, input bit fs);
    bit acc;
    acc = 0;
    pix_x = 16'(x);
    pix_y = 16'(y);
    pix_valid_in = 1'b1;
    frame_start = fs;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      if (pix_ready_out) begin
        q.push_back(model(pix_x, pix_y));
        acc = 1;
      end
      @(posedge clk); #1;
      if (frame_start) begin
        frame_start = 1'b0;
        frame_done();
      end
    end
    pix_valid_in = 1'b0;
    if (!acc) check("accept_timeout", 32'(pix_ready_out), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && q.size() > 0; c++) @(posedge clk);
    @(posedge clk); #1;
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < N; i++)
      set_obj(i, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 24)), int'($urandom_range(0, 24)),
              int'($urandom_range(1, 255)), ($urandom_range(0, 3) != 0));
    apply_cfg();
  endtask

  // Monitor: compares on every transfer and checks that stalled outputs stay put.
  initial begin
    exp_t         e;
    bit           held;
    logic [C-1:0] held_pix;
    held = 0;
    held_pix = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else if (pix_valid_out) begin
        if (held) check("stall_hold", 32'(pixel_out), 32'(held_pix));
        if (pix_ready_in) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'(pix_valid_out), 32'd0);
          end else begin
            e = q.pop_front();
            check("pixel", 32'(pixel_out), 32'(e.col));
            if (e.lat && !held) check("latency", 32'(cyc - e.cyc), 32'd2);
            if ((e.hits & (e.hits - 1'b1)) != '0) tb_acc |= e.hits;
          end
          held = 0;
        end else begin
          check("ready_low_on_stall", 32'(pix_ready_out), 32'd0);
          held = 1;
          held_pix = pixel_out;
        end
      end else begin
        if (held) check("valid_dropped", 32'(pix_valid_out), 32'd1);
        held = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    frame_start = 1'b0;
    pix_valid_in = 1'b0;
    pix_x = '0;
    pix_y = '0;
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 0, 1'b0);
    apply_cfg();
    clear_model();
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(pix_valid_out), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'h00);
    check("rst_collision", 32'(collision_out), 32'd0);
    check("rst_ready", 32'(pix_ready_out), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single object, edges of the rectangle, then config changes with and without frame_start.
    set_obj(0, 10, 20, 15, 100, 8'hFF, 1'b1);
    apply_cfg();
    frame();
    send(10, 20, 0);
    send(24, 119, 0);
    send(25, 20, 0);
    send(9, 20, 0);
    send(10, 120, 0);
    c_x[0] = 16'd100;
    apply_cfg();
    send(10, 20, 0);
    send(10, 20, 1);
    send(10, 20, 0);
    send(105, 20, 0);
    drain();

    // No wrap at the top of the coordinate range; zero width/height never hits.
    set_obj(0, 16'hFFF8, 0, 16, 10, 8'h33, 1'b1);
    set_obj(1, 0, 0, 0, 10, 8'h44, 1'b1);
    set_obj(2, 0, 0, 5, 0, 8'h66, 1'b1);
    apply_cfg();
    frame();
    send(2, 5, 0);
    send(16'hFFFA, 5, 0);
    send(0, 0, 0);
    send(16'hFFFF, 9, 0);
    drain();

    // Overlap priority and collision flags.
    set_obj(0, 40, 40, 20, 20, 8'hAA, 1'b1);
    set_obj(1, 50, 50, 5, 5, 8'h55, 1'b1);
    set_obj(2, 0, 0, 0, 0, 8'h00, 1'b0);
    apply_cfg();
    frame();
    send(50, 50, 0);
    send(45, 45, 0);
    drain();
    frame();
    check("collision_011", 32'(collision_out), 32'b011);

    // Reset with two pixels in flight.
    send(52, 52, 0);
    send(41, 41, 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(pix_valid_out), 32'd0);
    check("midrst_collision", 32'(collision_out), 32'd0);
    check("midrst_ready", 32'(pix_ready_out), 32'd1);
    q.delete();
    tb_acc = '0;
    clear_model();
    pix_valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pix_valid_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_output", 32'(pix_valid_out), 32'd0);
    frame();

    // Randomised traffic with random output back-pressure.
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      rand_cfg();
      frame();
      for (int k = 0; k < 8; k++)
        send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 7) == 0) rand_cfg();
        send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             ($urandom_range(0, 9) == 0));
      end
      drain();
    end
    rand_ready = 0;
    frame();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
